// File: rtl/text_tile_renderer.sv
// rtl/text_tile_renderer.sv - character-cell text renderer: cell fetch, glyph lookup, cursor blink, pixel colour
module text_tile_renderer #(
  parameter int COLS = 40,
  parameter int ROWS = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  hpos,
  input  logic [8:0]  vpos,
  input  logic        display_on,
  output logic [9:0]  ram_addr,
  input  logic [7:0]  ram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [9:0]  cursor_addr,
  input  logic        cursor_en,
  input  logic [3:0]  fg_color,
  input  logic [3:0]  bg_color,
  output logic [3:0]  rgb,
  output logic        pix_valid
);

  localparam logic [31:0] H_PIX = 32'(COLS * 8);
  localparam logic [31:0] V_PIX = 32'(ROWS * 8);

  // Stage 0: visibility test and cell index of the sampled position.
  // The index is only loaded when the position lies inside the grid,
  // so an out-of-grid product can never reach ram_addr.
  logic       s0_valid;
  logic [9:0] s0_addr;
  logic       s0_hit;
  logic       at_origin;

  assign s0_valid  = display_on && ({23'd0, hpos} < H_PIX) && ({23'd0, vpos} < V_PIX);
  assign s0_addr   = 10'(vpos[8:3]) * 10'(COLS) + 10'(hpos[8:3]);
  assign s0_hit    = (s0_addr == cursor_addr);
  assign at_origin = (hpos == 9'd0) && (vpos == 9'd0);

  // Pipeline side-band travelling alongside the RAM fetch; stage 2 lines up with ram_data.
  logic       s1_valid, s2_valid;
  logic [2:0] s1_hlow, s2_hlow;
  logic [2:0] s1_vlow, s2_vlow;
  logic       s1_hit, s2_hit;

  // Frame tick detection and blink counter.
  logic       origin_prev;
  logic [4:0] frame_cnt;
  logic       blink;

  assign blink = frame_cnt[4];

  // Glyph row lookup and pixel selection at stage 2.
  logic pix_bit;

  assign font_addr = {ram_data, s2_vlow};
  assign pix_bit   = font_data[3'd7 - s2_hlow] ^ (s2_hit & cursor_en & blink);

  // Cell address register: loads on visible samples, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr <= 10'd0;
    end else if (s0_valid) begin
      ram_addr <= s0_addr;
    end
  end

  // Two-deep delay of pixel offsets, validity and cursor hit; never stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_hlow  <= 3'd0;
      s1_vlow  <= 3'd0;
      s1_hit   <= 1'b0;
      s2_valid <= 1'b0;
      s2_hlow  <= 3'd0;
      s2_vlow  <= 3'd0;
      s2_hit   <= 1'b0;
    end else begin
      s1_valid <= s0_valid;
      s1_hlow  <= hpos[2:0];
      s1_vlow  <= vpos[2:0];
      s1_hit   <= s0_hit;
      s2_valid <= s1_valid;
      s2_hlow  <= s1_hlow;
      s2_vlow  <= s1_vlow;
      s2_hit   <= s1_hit;
    end
  end

  // Count one tick on the first cycle at the origin; repeated origin cycles are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      origin_prev <= 1'b0;
      frame_cnt   <= 5'd0;
    end else begin
      origin_prev <= at_origin;
      if (at_origin && !origin_prev) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end
  end

  // Output colour register: foreground/background for visible pixels, black otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb       <= 4'd0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= s2_valid;
      if (s2_valid) begin
        rgb <= pix_bit ? fg_color : bg_color;
      end else begin
        rgb <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_text_tile_renderer.sv
// tb/tb_text_tile_renderer.sv - scoreboard bench for text_tile_renderer
module tb_text_tile_renderer;

  logic        clk;
  logic        reset_n;
  logic [8:0]  hpos;
  logic [8:0]  vpos;
  logic        display_on;
  logic [9:0]  ram_addr;
  logic [7:0]  ram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [9:0]  cursor_addr;
  logic        cursor_en;
  logic [3:0]  fg_color;
  logic [3:0]  bg_color;
  logic [3:0]  rgb;
  logic        pix_valid;

  text_tile_renderer #(.COLS(40), .ROWS(25)) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .ram_addr(ram_addr), .ram_data(ram_data), .font_addr(font_addr), .font_data(font_data),
    .cursor_addr(cursor_addr), .cursor_en(cursor_en), .fg_color(fg_color), .bg_color(bg_color),
    .rgb(rgb), .pix_valid(pix_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Character RAM: synchronous read, data one cycle after the address.
  logic [7:0] mem [0:1023];
  always @(posedge clk) ram_data <= mem[ram_addr];

  // Font ROM: only glyph 65 is populated.
  function automatic logic [7:0] glyph(input logic [10:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (a[10:3] == 8'd65) begin
      case (a[2:0])
        3'd0: r = 8'h30;
        3'd1: r = 8'h78;
        3'd2: r = 8'hCC;
        3'd3: r = 8'hCC;
        3'd4: r = 8'hFC;
        3'd5: r = 8'hCC;
        3'd6: r = 8'hCC;
        default: r = 8'h00;
      endcase
    end
    return r;
  endfunction

  assign font_data = glyph(font_addr);

  typedef struct {
    int         due;
    logic [3:0] rgb;
    logic       pv;
  } pix_t;

  typedef struct {
    int          due;
    logic        is_font;
    logic [10:0] val;
  } addr_t;

  pix_t  pq[$];
  addr_t aq[$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pop every expectation that falls due in this cycle.
  pix_t  pe;
  addr_t ae;
  always @(negedge clk) begin
    if (reset_n) begin
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        pe = pq.pop_front();
        if (pe.due < cyc) chk("pix_late", 0, 1);
        else chk("rgb_pv", int'({rgb, pix_valid}), int'({pe.rgb, pe.pv}));
      end
      while (aq.size() > 0 && aq[0].due <= cyc) begin
        ae = aq.pop_front();
        if (ae.due < cyc) chk("addr_late", 0, 1);
        else if (ae.is_font) chk("font_addr", int'(font_addr), int'(ae.val));
        else chk("ram_addr", int'(ram_addr), int'(ae.val));
      end
    end
  end

  // One input vector; ea/ef < 0 means no address check for this vector.
  task automatic vec(input int h, input int v, input logic d, input logic [3:0] er,
                     input logic ep, input int ea, input int ef);
    @(negedge clk);
    hpos       = h[8:0];
    vpos       = v[8:0];
    display_on = d;
    pq.push_back('{cyc + 3, er, ep});
    if (ea >= 0) aq.push_back('{cyc + 1, 1'b0, 11'(ea)});
    if (ef >= 0) aq.push_back('{cyc + 2, 1'b1, 11'(ef)});
  endtask

  // Eight visible pixels of one cell row; expected colours packed first-pixel-in-MSB.
  task automatic row8(input int v, input int h0, input logic [31:0] exp, input int ea, input int ef);
    for (int i = 0; i < 8; i++) begin
      vec(h0 + i, v, 1'b1, exp[31 - 4*i -: 4], 1'b1, ea, ef);
    end
  endtask

  // Frame ticks with the display off: origin followed by a non-origin cycle.
  task automatic tick_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      vec(0, 0, 1'b0, 4'h0, 1'b0, -1, -1);
      vec(1, 0, 1'b0, 4'h0, 1'b0, -1, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0]  = 8'd65;
    mem[42] = 8'd65;

    reset_n     = 1'b0;
    hpos        = 9'd0;
    vpos        = 9'd0;
    display_on  = 1'b0;
    cursor_addr = 10'd0;
    cursor_en   = 1'b0;
    fg_color    = 4'hF;
    bg_color    = 4'h1;

    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_pv", int'(pix_valid), 0);
    chk("reset_ram_addr", int'(ram_addr), 0);
    hpos = 9'd1;
    reset_n = 1'b1;

    // Cell 0 rows 0 and 1 of glyph 65.
    row8(0, 0, 32'h11FF1111, 0, 'h208);
    row8(1, 0, 32'h1FFFF111, 0, 'h209);

    // Address arithmetic, then invalid samples leaving ram_addr alone.
    vec(17, 9, 1'b1, 4'hF, 1'b1, 42, 'h209);
    vec(5, 0, 1'b0, 4'h0, 1'b0, 42, -1);
    vec(320, 0, 1'b1, 4'h0, 1'b0, 42, -1);
    vec(0, 200, 1'b1, 4'h0, 1'b0, 42, -1);
    vec(319, 199, 1'b1, 4'h1, 1'b1, 999, 'h007);
    vec(8, 0, 1'b1, 4'h1, 1'b1, 1, -1);

    // Cursor on cell 0: blink low, then high (inverted), then wrapped back low.
    cursor_en = 1'b1;
    row8(0, 0, 32'h11FF1111, 0, 'h208);
    tick_pairs(14);
    row8(0, 0, 32'hFF11FFFF, 0, 'h208);
    vec(8, 0, 1'b1, 4'h1, 1'b1, 1, -1);
    tick_pairs(14);
    row8(0, 0, 32'h11FF1111, 0, 'h208);

    // Blink high again, stream, then reset mid-stream.
    tick_pairs(16);
    vec(0, 1, 1'b1, 4'hF, 1'b1, -1, -1);
    vec(1, 1, 1'b1, 4'h1, 1'b1, -1, -1);
    vec(2, 1, 1'b1, 4'h1, 1'b1, -1, -1);
    vec(3, 1, 1'b1, 4'h1, 1'b1, -1, -1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", int'(rgb), 0);
    chk("async_rst_pv", int'(pix_valid), 0);
    chk("async_rst_ram_addr", int'(ram_addr), 0);
    pq.delete();
    aq.delete();
    display_on = 1'b0;
    hpos = 9'd4;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Counter restarted from zero: cursor cell renders non-inverted.
    row8(0, 0, 32'h11FF1111, 0, 'h208);
    vec(1, 0, 1'b0, 4'h0, 1'b0, 0, -1);
    vec(2, 0, 1'b0, 4'h0, 1'b0, 0, -1);

    for (int i = 0; i < 20 && (pq.size() > 0 || aq.size() > 0); i++) @(negedge clk);
    if (pq.size() > 0 || aq.size() > 0) chk("drain_timeout", pq.size() + aq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
